ssim_classify_ctrl: RTL
=======================

Name: ssim_classify_ctrl

Overview:
Sequencer for the SSIM datapath in the digit classifier. On each start it advances the x image memory, then runs the SSIM engine once per class template (num = 0..NUM_CLASSES-1). Before each run it clears the engine and waits for the SSIM result. It keeps a running IEEE-754 maximum and reports the winning class. It sits between the top-level control and the ssim datapath, and owns that datapath's next_image, clr and num inputs.

Parameters:
NUM_CLASSES, 10, number of templates swept; 1..15.
CLR_CYCLES, 2, cycles ssim_clr is held high before each class run; >=1.
TIMEOUT_CYCLES, 4096, max cycles to wait for ssim_valid in one run.
TIMEOUT_WIDTH, 13, counter width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request a classification; sampled only in IDLE.
next_image  out  1  one-cycle pulse advancing the x image memories.
ssim_clr  out  1  clear to the SSIM datapath.
ssim_num  out  4  template index driven to the datapath.
ssim_out  in  32  SSIM result, float32.
ssim_valid  in  1  SSIM result valid.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a sweep completes.
best_num  out  4  winning class; 4'hF means no valid result.
best_ssim  out  32  SSIM of the winning class.
timeout_err  out  1  set if any class timed out during the last sweep.

Behaviour:
- Reset values: next_image=0, ssim_clr=1, ssim_num=0, busy=0, done=0, best_num=4'hF, best_ssim=32'hFF800000 (-inf), timeout_err=0. FSM enters IDLE.
- A reset asserted in any state returns the block to IDLE with the reset values on the next edge. No partial result is kept.
- IDLE:
  - ssim_clr=1.
  - When start=1: clear best_num, best_ssim and timeout_err to their reset values, set ssim_num=0, go to NEXT.
- NEXT (1 cycle): next_image=1, ssim_clr=1, then go to CLR.
- CLR (exactly CLR_CYCLES cycles):
  - ssim_clr=1; the cycle counter is reloaded on entry.
  - Then go to RUN.
- RUN:
  - ssim_clr=0; the timeout counter starts at 0 on entry.
  - If ssim_valid=1: capture ssim_out, go to CMP.
  - Else if the counter reaches TIMEOUT_CYCLES-1: set timeout_err=1, go to ADV with no update.
  - ssim_valid wins if it coincides with the last timeout cycle.
- CMP (1 cycle): if the captured value is strictly greater than best_ssim, load best_ssim and best_num=ssim_num. Then go to ADV.
- ADV (1 cycle):
  - If ssim_num==NUM_CLASSES-1, go to DONE.
  - Else ssim_num+1 and go to CLR. No new next_image within a sweep.
- DONE (1 cycle): done=1, then go to IDLE. best_* and timeout_err hold until the next accepted start.
- start outside IDLE is ignored. ssim_valid outside RUN is ignored.
- Float compare (combinational, no FP IP):
  - NaN (exp=FF, mant!=0) is never greater.
  - +0 and -0 are equal.
  - Signs differ: the positive value is greater.
  - Both positive: larger raw bits is greater.
  - Both negative: smaller raw bits is greater.
  - Ties keep the lower class index.
- Sweep latency with an ideal datapath: 1 + NUM_CLASSES*(CLR_CYCLES + R + 2) + 1 cycles from start, where R is the RUN dwell (>=1).

Optional Feature:
Macro SSIM_SCORE_LOG_EN.
- Defined:
  - Adds input score_rd_addr[3:0] and output score_rd_data[31:0].
  - An internal NUM_CLASSES x 32 register file records each class's captured ssim_out in CMP.
  - Timed-out classes record 32'h7FC00000.
  - Cleared to 0 on reset and on accepted start.
  - Read is combinational.
  - Addresses >= NUM_CLASSES read 0.
- Not defined: no extra ports or storage. Behaviour is otherwise identical.

Test Plan:
- Basic sweep: rst, start; model returns 0x3F000000 for all classes except class 7 = 0x3F400000 → one next_image pulse, ssim_num steps 0..9, done pulse, best_num=7, best_ssim=0x3F400000, timeout_err=0.
- Tie and negatives: class 2 = 0x3F800000, class 5 = 0x3F800000, others 0xBE800000 → best_num=2.
- NaN and zeros: all classes 0x7FC00000 → best_num=4'hF, best_ssim=0xFF800000. Rerun with class 0 = 0x80000000 and class 1 = 0x00000000 → best_num=0.
- Timeout: TIMEOUT_CYCLES=16; class 3 never asserts ssim_valid; class 4 = 0x3F000000, others 0x3E800000 → class 3 skipped after 16 cycles, timeout_err=1, best_num=4. Also check ssim_valid arriving on the 16th RUN cycle is accepted.
- Handshake/ignore: ssim_valid pulses during CLR and start pulses during RUN → no state change. ssim_clr is high for exactly CLR_CYCLES cycles before each RUN.
- Mid-run reset: rst during class 4's RUN → IDLE next cycle, all outputs at reset values. A fresh start then completes normally. With SSIM_SCORE_LOG_EN, the log matches the stimulus values for every address.

Source files
------------

// File: rtl/ssim_classify_ctrl.sv
// ssim_classify_ctrl
// Sequencer for the SSIM datapath of the digit classifier. A start advances
// the x image memory once, then sweeps every class template through the SSIM
// engine (clear, run, compare). It tracks the IEEE-754 maximum result and
// reports the winning class.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           classification request, sampled only in IDLE
//   next_image      one-cycle pulse advancing the x image memories
//   ssim_clr        clear to the SSIM datapath
//   ssim_num        template index driven to the datapath
//   ssim_out        SSIM result (float32), qualified by ssim_valid
//   busy            high in every state except IDLE
//   done            one-cycle pulse at the end of a sweep
//   best_num        winning class, 4'hF when no class produced a usable result
//   best_ssim       SSIM of the winning class (-inf when none)
//   timeout_err     some class timed out during the last sweep
//
// Optional build macro SSIM_SCORE_LOG_EN adds a per-class score log:
//   score_rd_addr   read address (combinational read)
//   score_rd_data   captured score; 32'h7FC00000 for a timed-out class,
//                   0 for addresses >= NUM_CLASSES
//
// state  | meaning
// IDLE   | waiting for start, datapath held in clear
// NEXT   | advance x image memory
// CLR    | hold ssim_clr for CLR_CYCLES cycles
// RUN    | wait for ssim_valid or timeout
// CMP    | compare captured score against the running maximum
// ADV    | step to the next class or finish the sweep
// DONE   | pulse done
module ssim_classify_ctrl #(
  parameter int NUM_CLASSES    = 10,
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        next_image,
  output logic        ssim_clr,
  output logic [3:0]  ssim_num,
  input  logic [31:0] ssim_out,
  input  logic        ssim_valid,
  output logic        busy,
  output logic        done,
  output logic [3:0]  best_num,
  output logic [31:0] best_ssim,
  output logic        timeout_err
`ifdef SSIM_SCORE_LOG_EN
  ,
  input  logic [3:0]  score_rd_addr,
  output logic [31:0] score_rd_data
`endif
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [3:0]  LAST    = 4'(NUM_CLASSES - 1);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NEXT, S_CLR, S_RUN, S_CMP, S_ADV, S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            clr_cnt;
  logic [TIMEOUT_WIDTH-1:0] to_cnt;
  logic [31:0]              captured;

  // Strict IEEE-754 a > b without FP IP. NaN on either side compares false,
  // and signed zeros are equal, so neither can displace the current best.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, both_zero;
    a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    if (a_nan || b_nan || both_zero) return 1'b0;
    if (a[31] != b[31])              return !a[31];
    if (!a[31])                      return a > b;
    return a < b;
  endfunction

  always_comb begin
    state_nxt  = state;
    next_image = 1'b0;
    ssim_clr   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        ssim_clr = 1'b1;
        if (start) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        next_image = 1'b1;
        ssim_clr   = 1'b1;
        state_nxt  = S_CLR;
      end
      S_CLR: begin
        ssim_clr = 1'b1;
        if (clr_cnt == '0) state_nxt = S_RUN;
      end
      S_RUN: begin
        // valid takes priority over a coincident final timeout cycle
        if (ssim_valid)             state_nxt = S_CMP;
        else if (to_cnt == TO_LAST) state_nxt = S_ADV;
      end
      S_CMP:   state_nxt = S_ADV;
      S_ADV:   state_nxt = (ssim_num == LAST) ? S_DONE : S_CLR;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ssim_num    <= 4'd0;
      clr_cnt     <= CLR_LOAD;
      to_cnt      <= '0;
      captured    <= 32'd0;
      best_num    <= 4'hF;
      best_ssim   <= NEG_INF;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            ssim_num    <= 4'd0;
            best_num    <= 4'hF;
            best_ssim   <= NEG_INF;
            timeout_err <= 1'b0;
          end
        end
        S_NEXT: clr_cnt <= CLR_LOAD;
        S_CLR: begin
          clr_cnt <= clr_cnt - 1'b1;
          to_cnt  <= '0;
        end
        S_RUN: begin
          to_cnt <= to_cnt + 1'b1;
          if (ssim_valid)             captured    <= ssim_out;
          else if (to_cnt == TO_LAST) timeout_err <= 1'b1;
        end
        S_CMP: begin
          if (fp_gt(captured, best_ssim)) begin
            best_ssim <= captured;
            best_num  <= ssim_num;
          end
        end
        S_ADV: begin
          if (ssim_num != LAST) begin
            ssim_num <= ssim_num + 4'd1;
            clr_cnt  <= CLR_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SSIM_SCORE_LOG_EN
  logic [31:0] score_log [NUM_CLASSES];

  always_ff @(posedge clk) begin
    if (rst || (state == S_IDLE && start)) begin
      for (int i = 0; i < NUM_CLASSES; i++) score_log[i] <= 32'd0;
    end else if (state == S_CMP) begin
      score_log[ssim_num] <= captured;
    end else if (state == S_RUN && !ssim_valid && to_cnt == TO_LAST) begin
      score_log[ssim_num] <= QNAN;
    end
  end

  always_comb begin
    score_rd_data = 32'd0;
    if (score_rd_addr < 4'(NUM_CLASSES)) score_rd_data = score_log[score_rd_addr];
  end
`endif

endmodule
